// File: rtl/pe_local_store_agu.sv
// Local-store address generator for one PE: after a single start it walks a 2-D
// kernel window and emits paired kernel/neuron addresses under valid/stall control.
module pe_local_store_agu #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int D     = 1 << depth
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         cfgWrite,
  input  logic [2:0]   cfgSel,
  input  logic [A-1:0] cfgData,
  input  logic         start,
  input  logic         mode,
  input  logic         stall,
  output logic         addrValid,
  output logic [A-1:0] kernelAddress,
  output logic [A-1:0] neuronAddress,
  output logic         lastCol,
  output logic         lastRow,
  output logic         busy,
  output logic         done
);

  localparam logic [A-1:0] FIELD_MASK = A'(D - 1);
  localparam logic [A-1:0] ONE        = A'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, next_state;
  logic [A-1:0]       r, c;
  logic               mode_r;
  logic [A-1:0]       k_step, n_step, k_rows, k_cols;
  logic [depth-1:0]   tr, tc, k_row_ofst, k_col_ofst, n_row_ofst, n_col_ofst;
  logic               col_end, row_end;

  // Offset and stride fields are zero-extended into the address width.
  function automatic logic [A-1:0] ext(input logic [depth-1:0] v);
    return A'(v) & FIELD_MASK;
  endfunction

  assign col_end = (c == k_cols - ONE);
  assign row_end = (r == k_rows - ONE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (k_rows != '0 && k_cols != '0) ? RUN : DONE;
      RUN:     if (!stall && col_end && row_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    addrValid = (state == RUN);
    done      = (state == DONE);
    busy      = (state != IDLE);
    lastCol   = addrValid && col_end;
    lastRow   = addrValid && row_end;
  end

  // Loop counters: column is the inner loop, row the outer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r      <= '0;
      c      <= '0;
      mode_r <= 1'b0;
    end else if (state == IDLE && start) begin
      r      <= '0;
      c      <= '0;
      mode_r <= mode;
    end else if (state == RUN && !stall) begin
      if (!col_end) begin
        c <= c + ONE;
      end else if (!row_end) begin
        c <= '0;
        r <= r + ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      k_step     <= '0;
      n_step     <= '0;
      k_rows     <= '0;
      k_cols     <= '0;
      tr         <= '0;
      tc         <= '0;
      k_row_ofst <= '0;
      k_col_ofst <= '0;
      n_row_ofst <= '0;
      n_col_ofst <= '0;
    end else if (cfgWrite && state == IDLE) begin
      case (cfgSel)
        3'd0: k_step <= cfgData;
        3'd1: n_step <= cfgData;
        3'd2: k_rows <= cfgData;
        3'd3: k_cols <= cfgData;
        3'd4: begin
          tr <= cfgData[depth-1:0];
          tc <= cfgData[2*depth-1:depth];
        end
        3'd5: begin
          k_col_ofst <= cfgData[depth-1:0];
          k_row_ofst <= cfgData[2*depth-1:depth];
        end
        3'd6: begin
          n_col_ofst <= cfgData[depth-1:0];
          n_row_ofst <= cfgData[2*depth-1:depth];
        end
        default: ;
      endcase
    end
  end

  // Address stage: pure combinational function of counters and config, wraps mod 2^A.
  always_comb begin
    if (mode_r) begin
      kernelAddress = ext(k_row_ofst) * k_step + ext(k_col_ofst) + r * k_cols + c;
      neuronAddress = ext(n_row_ofst) * n_step + ext(n_col_ofst);
    end else begin
      kernelAddress = (ext(k_row_ofst) + r * ext(tr)) * k_step + ext(k_col_ofst) + c * ext(tc);
      neuronAddress = (ext(n_row_ofst) + r) * n_step + ext(n_col_ofst) + c;
    end
  end

endmodule

// File: tb/tb_pe_local_store_agu.sv
// Bench for pe_local_store_agu: directed walks plus randomized configs and stalls
// against a nested-loop reference model of the window walk.
module tb_pe_local_store_agu;

  localparam int A = 7;

  logic         CLK = 1'b0;
  logic         RST, cfgWrite, start, mode, stall;
  logic [2:0]   cfgSel;
  logic [A-1:0] cfgData;
  logic         addrValid, lastCol, lastRow, busy, done;
  logic [A-1:0] kernelAddress, neuronAddress;

  int total = 0;
  int bad   = 0;

  int m_kstep, m_nstep, m_krows, m_kcols, m_tr, m_tc, m_kro, m_kco, m_nro, m_nco;
  int eq_k[$], eq_n[$], eq_lc[$], eq_lr[$], got_k[$];
  int pass_valid;

  pe_local_store_agu #(.depth(2), .A(A)) dut (
    .CLK(CLK), .RST(RST), .cfgWrite(cfgWrite), .cfgSel(cfgSel), .cfgData(cfgData),
    .start(start), .mode(mode), .stall(stall), .addrValid(addrValid),
    .kernelAddress(kernelAddress), .neuronAddress(neuronAddress),
    .lastCol(lastCol), .lastRow(lastRow), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_kstep = 0; m_nstep = 0; m_krows = 0; m_kcols = 0; m_tr = 0; m_tc = 0;
    m_kro = 0; m_kco = 0; m_nro = 0; m_nco = 0;
  endtask

  task automatic cfg_wr(input int sel, input int data);
    @(negedge CLK);
    cfgWrite = 1'b1; cfgSel = 3'(sel); cfgData = A'(data);
    case (sel)
      0: m_kstep = data;
      1: m_nstep = data;
      2: m_krows = data;
      3: m_kcols = data;
      4: begin m_tr = data & 3; m_tc = (data >> 2) & 3; end
      5: begin m_kco = data & 3; m_kro = (data >> 2) & 3; end
      6: begin m_nco = data & 3; m_nro = (data >> 2) & 3; end
      default: ;
    endcase
    @(negedge CLK);
    cfgWrite = 1'b0;
  endtask

  task automatic build_expect(input int md);
    eq_k.delete(); eq_n.delete(); eq_lc.delete(); eq_lr.delete();
    for (int r = 0; r < m_krows; r++)
      for (int c = 0; c < m_kcols; c++) begin
        if (md == 0) begin
          eq_k.push_back(((m_kro + r * m_tr) * m_kstep + m_kco + c * m_tc) % 128);
          eq_n.push_back(((m_nro + r) * m_nstep + m_nco + c) % 128);
        end else begin
          eq_k.push_back((m_kro * m_kstep + m_kco + r * m_kcols + c) % 128);
          eq_n.push_back((m_nro * m_nstep + m_nco) % 128);
        end
        eq_lc.push_back(c == m_kcols - 1);
        eq_lr.push_back(r == m_krows - 1);
      end
  endtask

  // smode: 0 no stall, 1 random stall, 2 three stall cycles on the 2nd address.
  // rst_at > 0 asserts RST (with start) on that valid cycle and abandons the pass.
  task automatic run_pass(input int md, input int smode, input int rst_at);
    int idx, held;
    bit fin;
    build_expect(md);
    @(negedge CLK);
    start = 1'b1; mode = md[0];
    @(negedge CLK);
    start = 1'b0; mode = 1'b0;
    idx = 0; held = 0; fin = 0; pass_valid = 0; got_k.delete();
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      if (cyc == 0) chk("first_valid", int'(addrValid), int'(eq_k.size() != 0));
      if (done) begin
        chk("done_count", idx, eq_k.size());
        chk("done_novalid", int'(addrValid), 0);
        chk("done_busy", int'(busy), 1);
        fin = 1;
      end else if (addrValid) begin
        pass_valid++;
        chk("busy_run", int'(busy), 1);
        if (rst_at > 0 && pass_valid == rst_at) begin
          RST = 1'b1; start = 1'b1; stall = 1'b0;
          return;
        end
        if (idx < eq_k.size()) begin
          chk("kaddr", int'(kernelAddress), eq_k[idx]);
          chk("naddr", int'(neuronAddress), eq_n[idx]);
          chk("lastcol", int'(lastCol), eq_lc[idx]);
          chk("lastrow", int'(lastRow), eq_lr[idx]);
        end else begin
          chk("overrun", idx, eq_k.size() - 1);
        end
        if (smode == 1) stall = ($urandom_range(0, 2) == 0);
        else if (smode == 2 && idx == 1 && held < 3) begin stall = 1'b1; held++; end
        else stall = 1'b0;
        if (!stall) begin
          got_k.push_back(int'(kernelAddress));
          idx++;
        end
      end else begin
        chk("gap_valid", int'(addrValid), 1);
        fin = 1;
      end
    end
    stall = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    @(negedge CLK);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
  endtask

  task automatic cfg_scenario1();
    cfg_wr(0, 8); cfg_wr(1, 10); cfg_wr(2, 2); cfg_wr(3, 3);
    cfg_wr(4, 5); cfg_wr(5, 0); cfg_wr(6, 0);
  endtask

  task automatic check_seq(input string tag, input int base_list[6]);
    chk({tag, "_len"}, got_k.size(), 6);
    for (int i = 0; i < 6 && i < got_k.size(); i++) chk(tag, got_k[i], base_list[i]);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, int'(addrValid), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_lc"},    int'(lastCol), 0);
    chk({tag, "_lr"},    int'(lastRow), 0);
    chk({tag, "_k"},     int'(kernelAddress), 0);
    chk({tag, "_n"},     int'(neuronAddress), 0);
  endtask

  initial begin
    int seq1[6] = '{0, 1, 2, 8, 9, 10};
    int seq2[6] = '{9, 11, 13, 25, 27, 29};
    RST = 1'b1; cfgWrite = 1'b0; cfgSel = '0; cfgData = '0;
    start = 1'b0; mode = 1'b0; stall = 1'b0;
    model_clear();
    repeat (3) @(negedge CLK);
    check_zero_outputs("reset");
    RST = 1'b0;

    // Basic compute walk.
    cfg_scenario1();
    run_pass(0, 0, 0);
    check_seq("seq1", seq1);

    // Strided walk with kernel offsets.
    cfg_wr(4, (2 << 2) | 2); cfg_wr(5, (1 << 2) | 1);
    run_pass(0, 0, 0);
    check_seq("seq2", seq2);

    // Dense kernel load walk.
    cfg_wr(0, 16); cfg_wr(2, 3); cfg_wr(3, 4); cfg_wr(5, (1 << 2) | 2);
    run_pass(1, 0, 0);
    chk("load_len", got_k.size(), 12);
    for (int i = 0; i < got_k.size(); i++) chk("load_seq", got_k[i], 18 + i);

    // Stall on the 2nd address for three cycles.
    cfg_scenario1();
    run_pass(0, 2, 0);
    chk("stall_len", pass_valid, 9);
    check_seq("stall_seq", seq1);

    // Zero column count: straight to DONE; a write during DONE must be dropped.
    cfg_wr(3, 0);
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    chk("zero_done", int'(done), 1);
    chk("zero_valid", int'(addrValid), 0);
    chk("zero_busy", int'(busy), 1);
    cfgWrite = 1'b1; cfgSel = 3'd0; cfgData = A'(99);
    @(negedge CLK); cfgWrite = 1'b0;
    chk("zero_idle", int'(busy), 0);
    cfg_wr(3, 3);
    run_pass(0, 0, 0);
    check_seq("blocked_wr", seq1);

    // Reset on the 4th valid cycle with start held.
    run_pass(0, 0, 4);
    @(negedge CLK);
    check_zero_outputs("midrst");
    RST = 1'b0; start = 1'b0;
    model_clear();
    run_pass(0, 0, 0);
    cfg_scenario1();
    run_pass(0, 0, 0);
    check_seq("post_rst", seq1);

    // Randomized configurations, modes and stalls.
    for (int t = 0; t < 16; t++) begin
      cfg_wr(0, $urandom_range(0, 127));
      cfg_wr(1, $urandom_range(0, 127));
      cfg_wr(2, $urandom_range(0, 5));
      cfg_wr(3, $urandom_range(0, 5));
      cfg_wr(4, $urandom_range(0, 15));
      cfg_wr(5, $urandom_range(0, 15));
      cfg_wr(6, $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) cfg_wr(7, $urandom_range(0, 127));
      run_pass($urandom_range(0, 1), 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
